// File: rtl/disp_seg_scan_pkg.sv
// Shared display definitions: hex segment font, blank pattern and blink phase type.
// Segment order is {dp,g,f,e,d,c,b,a}, active-low; the font leaves the dp bit dark.
package disp_seg_scan_pkg;

    typedef logic [7:0] seg_t;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } blink_ph_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    function automatic seg_t hex_font(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/disp_seg_scan_if.sv
// Producer-to-scanner load bus: display contents offered under valid, taken on a one-cycle ready.
// The producer holds every field stable while valid is high until ready is seen.
interface disp_seg_scan_if #(
    parameter int NDIG     = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*NDIG-1:0]   disp_data;
    logic [NDIG-1:0]     dp_in;
    logic [NDIG-1:0]     digit_en;
    logic                blank_lz;
    logic [BRIGHT_W-1:0] bright;
    logic [NDIG-1:0]     blink_mask;
    logic                data_valid;
    logic                data_ready;

    modport master (
        output disp_data, dp_in, digit_en, blank_lz, bright, blink_mask, data_valid,
        input  data_ready
    );

    modport slave (
        input  disp_data, dp_in, digit_en, blank_lz, bright, blink_mask, data_valid,
        output data_ready
    );
endinterface

// File: rtl/seg7_font.sv
// Combinational hex nibble to active-low 7-segment pattern, dp segment off; zero latency, no flow control.
module seg7_font
    import disp_seg_scan_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg_t       o_seg
);
    assign o_seg = hex_font(i_nib);
endmodule

// File: rtl/disp_seg_scan.sv
// Multiplexed NDIG-digit 7-segment scanner with PWM, blink, leading-zero blanking; outputs 1 cycle after scan state.
// New contents are accepted only on the frame-boundary ready strobe; producer holds valid until then.
module disp_seg_scan
    import disp_seg_scan_pkg::*;
#(
    parameter int NDIG         = 8,
    parameter int DIV_LOG2     = 16,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    disp_seg_scan_if.slave  i_bus,
    output logic            o_frame,
    output logic [NDIG-1:0] o_an,
    output seg_t            o_seg
);
    localparam int SEL_W = $clog2(NDIG);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NDIG - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [DIV_LOG2-1:0] r_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic [BLK_W-1:0]    r_blink_cnt;
    blink_ph_t           r_phase;

    logic [4*NDIG-1:0]   r_data;
    logic [NDIG-1:0]     r_dp;
    logic [NDIG-1:0]     r_en;
    logic [NDIG-1:0]     r_blink;
    logic [BRIGHT_W-1:0] r_bright;
    logic                r_blank;

    logic                r_frame;
    logic [NDIG-1:0]     r_an;
    seg_t                r_seg;

    logic                w_tick;
    logic                w_fb;
    logic                w_load;
    logic                w_pwm_on;
    logic                w_vis;
    logic [NDIG-1:0]     w_lz;
    logic [3:0]          w_nib;
    seg_t                w_font;

    assign w_tick           = &r_cnt;
    assign w_fb             = w_tick && (r_sel == SEL_LAST);
    assign i_bus.data_ready = w_fb && !i_rst;
    assign w_load           = i_bus.data_valid && i_bus.data_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_tick) begin
                r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
            r_phase     <= PH_ON;
        end else if (w_fb) begin
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= (r_phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Shadows change only at the frame boundary, so a frame never mixes old and new contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data   <= '0;
            r_dp     <= '0;
            r_en     <= '1;
            r_bright <= '1;
            r_blank  <= 1'b0;
            r_blink  <= '0;
        end else if (w_load) begin
            r_data   <= i_bus.disp_data;
            r_dp     <= i_bus.dp_in;
            r_en     <= i_bus.digit_en;
            r_bright <= i_bus.bright;
            r_blank  <= i_bus.blank_lz;
            r_blink  <= i_bus.blink_mask;
        end
    end

    // Zero run propagates down from the most significant digit; digit 0 always shows.
    always_comb begin : p_lz
        logic v_run;
        w_lz  = '0;
        v_run = r_blank;
        for (int i = NDIG - 1; i >= 1; i--) begin
            v_run   = v_run && (r_data[4*i +: 4] == 4'h0);
            w_lz[i] = v_run;
        end
    end

    assign w_nib    = r_data[{r_sel, 2'b00} +: 4];
    assign w_pwm_on = (r_bright == {BRIGHT_W{1'b1}}) ||
                      (r_cnt[DIV_LOG2-1 -: BRIGHT_W] < r_bright);
    assign w_vis    = r_en[r_sel] && !w_lz[r_sel] &&
                      !((r_phase == PH_OFF) && r_blink[r_sel]) && w_pwm_on;

    seg7_font u_font (
        .i_nib (w_nib),
        .o_seg (w_font)
    );

    // Anode and segments are registered together so a slot change can never overlap two anodes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame <= 1'b0;
            r_an    <= '1;
            r_seg   <= SEG_BLANK;
        end else begin
            r_frame <= w_fb;
            if (w_vis) begin
                r_an  <= ~(NDIG'(1) << r_sel);
                r_seg <= w_font & {~r_dp[r_sel], 7'h7F};
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign o_frame = r_frame;
    assign o_an    = r_an;
    assign o_seg   = r_seg;
endmodule

// File: tb/tb_disp_seg_scan.sv
// Bench for disp_seg_scan: 4-digit and 5-digit instances against a frame/slot arithmetic reference model.
module tb_disp_seg_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [19:0] t_data;
    logic [4:0]  t_dp, t_en, t_blink;
    logic        t_blank;
    logic [1:0]  t_bright;
    logic [1:0]  t_valid;

    disp_seg_scan_if #(.NDIG(4), .BRIGHT_W(2)) bus4();
    disp_seg_scan_if #(.NDIG(5), .BRIGHT_W(2)) bus5();

    assign bus4.disp_data  = t_data[15:0];
    assign bus4.dp_in      = t_dp[3:0];
    assign bus4.digit_en   = t_en[3:0];
    assign bus4.blank_lz   = t_blank;
    assign bus4.bright     = t_bright;
    assign bus4.blink_mask = t_blink[3:0];
    assign bus4.data_valid = t_valid[0];
    assign bus5.disp_data  = t_data;
    assign bus5.dp_in      = t_dp;
    assign bus5.digit_en   = t_en;
    assign bus5.blank_lz   = t_blank;
    assign bus5.bright     = t_bright;
    assign bus5.blink_mask = t_blink;
    assign bus5.data_valid = t_valid[1];

    logic       frame4, frame5;
    logic [3:0] an4;
    logic [4:0] an5;
    logic [7:0] seg4, seg5;

    disp_seg_scan #(.NDIG(4), .DIV_LOG2(2), .BRIGHT_W(2), .BLINK_FRAMES(2)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_bus(bus4), .o_frame(frame4), .o_an(an4), .o_seg(seg4));
    disp_seg_scan #(.NDIG(5), .DIV_LOG2(2), .BRIGHT_W(2), .BLINK_FRAMES(2)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_bus(bus5), .o_frame(frame5), .o_an(an5), .o_seg(seg5));

    int errors = 0;
    int checks = 0;

    logic [7:0] font_tab [16];
    int         nd [2];

    // Reference model: k cycles since reset; slot and frame follow from plain division.
    int         m_k [2];
    logic [19:0] m_data [2];
    logic [4:0] m_dp [2], m_en [2], m_blink [2];
    logic [1:0] m_bright [2];
    logic       m_blank [2];
    logic       m_fb [2];
    logic       acc [2];
    logic [4:0] e_an [2];
    logic [7:0] e_seg [2];
    logic       e_frame [2], e_rdy [2];
    int         rdy_cnt [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_pre(input int i);
        int cnt, slot, frames;
        logic [4:0] mask;
        logic [3:0] nib;
        logic lz, vis;
        mask = 5'((1 << nd[i]) - 1);
        if (rst) begin
            e_an[i] = mask; e_seg[i] = 8'hFF; e_frame[i] = 1'b0; e_rdy[i] = 1'b0; m_fb[i] = 1'b0;
        end else begin
            cnt    = m_k[i] % 4;
            slot   = (m_k[i] / 4) % nd[i];
            frames = m_k[i] / (4 * nd[i]);
            m_fb[i] = (m_k[i] % (4 * nd[i])) == (4 * nd[i] - 1);
            nib = 4'(m_data[i] >> (4 * slot));
            lz  = (slot > 0) && m_blank[i] && ((m_data[i] >> (4 * slot)) == 20'h0);
            vis = m_en[i][slot] && !lz && !(((frames / 2) % 2 == 1) && m_blink[i][slot]) &&
                  ((m_bright[i] == 2'd3) || (cnt < int'(m_bright[i])));
            e_an[i]    = vis ? (mask & ~5'(1 << slot)) : mask;
            e_seg[i]   = vis ? (m_dp[i][slot] ? (font_tab[nib] & 8'h7F) : font_tab[nib]) : 8'hFF;
            e_frame[i] = m_fb[i];
            e_rdy[i]   = m_fb[i];
        end
    endtask

    task automatic model_post(input int i);
        logic [19:0] dmask;
        dmask  = (i == 0) ? 20'h0FFFF : 20'hFFFFF;
        acc[i] = 1'b0;
        if (rst) begin
            m_k[i] = 0; m_data[i] = '0; m_dp[i] = '0; m_en[i] = '1;
            m_bright[i] = 2'd3; m_blank[i] = 1'b0; m_blink[i] = '0;
        end else begin
            if (m_fb[i] && t_valid[i]) begin
                acc[i] = 1'b1;
                m_data[i] = t_data & dmask; m_dp[i] = t_dp; m_en[i] = t_en;
                m_bright[i] = t_bright; m_blank[i] = t_blank; m_blink[i] = t_blink;
            end
            m_k[i]++;
        end
    endtask

    // Entered just after a falling edge with inputs settled; returns at the next falling edge.
    task automatic step();
        model_pre(0);
        model_pre(1);
        #1;
        chk("ready4", 32'(bus4.data_ready), 32'(e_rdy[0]));
        chk("ready5", 32'(bus5.data_ready), 32'(e_rdy[1]));
        rdy_cnt[0] += int'(bus4.data_ready);
        rdy_cnt[1] += int'(bus5.data_ready);
        @(posedge clk);
        #1;
        chk("an4", 32'(an4), 32'(e_an[0][3:0]));
        chk("seg4", 32'(seg4), 32'(e_seg[0]));
        chk("frame4", 32'(frame4), 32'(e_frame[0]));
        chk("an5", 32'(an5), 32'(e_an[1]));
        chk("seg5", 32'(seg5), 32'(e_seg[1]));
        chk("frame5", 32'(frame5), 32'(e_frame[1]));
        model_post(0);
        model_post(1);
        if (acc[0]) t_valid[0] = 1'b0;
        if (acc[1]) t_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input int i, input logic [19:0] d, input logic [4:0] dp, input logic [4:0] en,
                        input logic bl, input logic [1:0] br, input logic [4:0] bm);
        int n;
        t_data = d; t_dp = dp; t_en = en; t_blank = bl; t_bright = br; t_blink = bm;
        t_valid[i] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc[i] && n < 60);
        chk("accept", 32'(acc[i]), 32'd1);
        t_valid[i] = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        blank;
        logic [1:0]  bright;
        logic [1:0]  dig;
        logic [3:0]  an;
        logic [7:0]  seg;
    } vec_t;

    vec_t vt [16];
    int   duty_br  [3];
    int   duty_exp [3];
    int   blink_exp [4];

    initial begin
        int n, lit, c_dis, c_d0, nfr;
        logic [4:0] ea5;

        font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                     8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        nd = '{4, 5};
        rdy_cnt = '{0, 0};
        duty_br  = '{1, 0, 3};
        duty_exp = '{4, 0, 16};
        blink_exp = '{4, 0, 0, 4};
        //             data      dp    en    blk  br    dig   an    seg
        vt[0]  = '{16'h12A0, 4'h0, 4'hF, 1'b0, 2'd3, 2'd0, 4'hE, 8'hC0};
        vt[1]  = '{16'h12A0, 4'h0, 4'hF, 1'b0, 2'd3, 2'd1, 4'hD, 8'h88};
        vt[2]  = '{16'h12A0, 4'h0, 4'hF, 1'b0, 2'd3, 2'd2, 4'hB, 8'hA4};
        vt[3]  = '{16'h12A0, 4'h0, 4'hF, 1'b0, 2'd3, 2'd3, 4'h7, 8'hF9};
        vt[4]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 2'd3, 4'hF, 8'hFF};
        vt[5]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 2'd2, 4'hF, 8'hFF};
        vt[6]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 2'd1, 4'hD, 8'h92};
        vt[7]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 2'd0, 4'hE, 8'hC0};
        vt[8]  = '{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3, 2'd0, 4'hE, 8'hC0};
        vt[9]  = '{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3, 2'd1, 4'hF, 8'hFF};
        vt[10] = '{16'h12A0, 4'h1, 4'hF, 1'b0, 2'd3, 2'd0, 4'hE, 8'h40};
        vt[11] = '{16'h12A0, 4'h0, 4'hF, 1'b0, 2'd0, 2'd0, 4'hF, 8'hFF};
        vt[12] = '{16'h12A0, 4'h0, 4'hB, 1'b0, 2'd3, 2'd2, 4'hF, 8'hFF};
        vt[13] = '{16'h12A0, 4'h0, 4'hF, 1'b0, 2'd1, 2'd3, 4'h7, 8'hF9};
        vt[14] = '{16'h0F00, 4'h0, 4'hF, 1'b1, 2'd3, 2'd3, 4'hF, 8'hFF};
        vt[15] = '{16'h0F00, 4'h0, 4'hF, 1'b1, 2'd3, 2'd2, 4'hB, 8'h8E};

        rst = 1'b1; t_data = '0; t_dp = '0; t_en = '0; t_blank = 1'b0;
        t_bright = 2'd0; t_blink = '0; t_valid = 2'b00;
        @(negedge clk);
        step();
        step();
        chk("reset an4", 32'(an4), 32'hF);
        chk("reset seg4", 32'(seg4), 32'hFF);
        chk("reset frame4", 32'(frame4), 32'h0);
        rst = 1'b0;
        step();
        chk("post-reset an4", 32'(an4), 32'hE);
        chk("post-reset seg4", 32'(seg4), 32'hC0);

        for (int v = 0; v < 16; v++) begin
            load(0, {4'h0, vt[v].data}, {1'b0, vt[v].dp}, {1'b1, vt[v].en},
                 vt[v].blank, vt[v].bright, 5'h00);
            repeat (4 * int'(vt[v].dig)) step();
            step();
            chk($sformatf("vec%0d an", v), 32'(an4), 32'(vt[v].an));
            chk($sformatf("vec%0d seg", v), 32'(seg4), 32'(vt[v].seg));
        end

        for (int b = 0; b < 3; b++) begin
            load(0, 20'h012A0, 5'h00, 5'h1F, 1'b0, 2'(duty_br[b]), 5'h00);
            lit = 0;
            rdy_cnt[0] = 0;
            repeat (16) begin
                step();
                if (an4 != 4'hF) lit++;
            end
            chk($sformatf("duty bright=%0d", duty_br[b]), 32'(lit), 32'(duty_exp[b]));
            chk("ready per frame4", 32'(rdy_cnt[0]), 32'd1);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        load(0, 20'h012A0, 5'h01, 5'h1F, 1'b0, 2'd3, 5'h02);
        for (int f = 0; f < 4; f++) begin
            lit = 0;
            for (int j = 0; j < 16; j++) begin
                step();
                if (f == 0 && j == 0) chk("dp seg digit0", 32'(seg4), 32'h40);
                if (an4 == 4'hD) lit++;
            end
            chk($sformatf("blink frame%0d", f), 32'(lit), 32'(blink_exp[f]));
        end

        load(1, 20'h12345, 5'h00, 5'h1F, 1'b0, 2'd3, 5'h00);
        for (int j = 0; j < 20; j++) begin
            step();
            if (j % 4 == 0) begin
                ea5 = ~(5'b00001 << (j / 4));
                chk($sformatf("scan5 slot%0d", j / 4), 32'(an5), 32'(ea5));
            end
        end
        load(1, 20'h12345, 5'h00, 5'h0F, 1'b0, 2'd3, 5'h00);
        c_dis = 0; c_d0 = 0; nfr = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (an5 == 5'h0F) c_dis++;
            if (an5 == 5'h1E) c_d0++;
            if (frame5) nfr++;
        end
        chk("digit4 disabled", 32'(c_dis), 32'd0);
        chk("digit0 lit5", 32'(c_d0), 32'd4);
        chk("frames per 20", 32'(nfr), 32'd1);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame5 && n < 40);
        chk("frame period5", 32'(n), 32'd20);

        repeat (6) step();
        t_data = 20'hFFFFF; t_valid[0] = 1'b1; rst = 1'b1;
        #1;
        chk("ready in reset", 32'(bus4.data_ready), 32'h0);
        step();
        chk("mid rst an4", 32'(an4), 32'hF);
        chk("mid rst seg4", 32'(seg4), 32'hFF);
        chk("mid rst frame4", 32'(frame4), 32'h0);
        rst = 1'b0; t_valid[0] = 1'b0;
        step();
        chk("restart an4", 32'(an4), 32'hE);
        chk("restart seg4", 32'(seg4), 32'hC0);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (t_valid == 2'b00 && $urandom_range(0, 5) == 0) begin
                for (int d = 0; d < 5; d++) begin
                    t_data[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                end
                t_dp = 5'($urandom); t_en = 5'($urandom) | 5'($urandom);
                t_blank = 1'($urandom); t_bright = 2'($urandom);
                t_blink = 5'($urandom);
                t_valid = 2'($urandom_range(1, 3));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
